// File: rtl/bcd_digit_scanner_if.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_digit_scanner_if
//  Purpose  : Groups the control inputs and the scanned display outputs of
//             bcd_digit_scanner into one bundle.
//  Signals  : step, up, clr                -- count control (master -> slave)
//             w, x, y, z                    -- selected BCD digit, w = MSB
//             digit_sel[3:0]                -- one-hot digit enable, bit0 = units
//             blank                         -- selected digit is a leading zero
//             wrap                          -- one-cycle count wrap pulse
//  Revision : 1.0  initial release
// ============================================================================
interface bcd_digit_scanner_if;
    logic       step;
    logic       up;
    logic       clr;
    logic       w;
    logic       x;
    logic       y;
    logic       z;
    logic [3:0] digit_sel;
    logic       blank;
    logic       wrap;

    modport master (
        output step, up, clr,
        input  w, x, y, z, digit_sel, blank, wrap
    );

    modport slave (
        input  step, up, clr,
        output w, x, y, z, digit_sel, blank, wrap
    );
endinterface
`default_nettype wire

// File: rtl/bcd_digit_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_digit_scanner
//  Purpose  : Four-digit BCD up/down counter with a time-multiplexed digit
//             scanner feeding a single seven-segment decoder.
//  Params   : SCAN_DIV -- cycles each digit slot is held (1..65535)
//             LZB      -- 1 enables leading-zero blanking
//  Ports    : clk  -- clock, rising edge
//             rst  -- asynchronous active-high reset
//             bus  -- bcd_digit_scanner_if.slave (step/up/clr in;
//                     w,x,y,z/digit_sel/blank/wrap out, all registered)
//  Revision : 1.0  initial release
// ============================================================================
module bcd_digit_scanner #(
    parameter int SCAN_DIV = 4,
    parameter int LZB      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    bcd_digit_scanner_if.slave    bus
);

    localparam logic [15:0] c_PRE_LAST = 16'(SCAN_DIV - 1);

    localparam logic [1:0] c_S0 = 2'd0;
    localparam logic [1:0] c_S1 = 2'd1;
    localparam logic [1:0] c_S2 = 2'd2;
    localparam logic [1:0] c_S3 = 2'd3;

    // Count state, r_d[0] = units
    logic [3:0]  r_d [4];

    // Scanner state and registered outputs
    logic [15:0] r_pre;
    logic [1:0]  r_slot;
    logic [3:0]  r_sel;
    logic [3:0]  r_dig;
    logic        r_blank;
    logic        r_wrap;

    logic [3:0]  w_is9;
    logic [3:0]  w_is0;
    logic [4:0]  w_inc_en;
    logic [4:0]  w_dec_en;
    logic [3:0]  w_zero_from;
    logic [3:0]  w_d_inc [4];
    logic [3:0]  w_d_dec [4];
    logic        w_adv;
    logic [1:0]  w_slot_next;
    logic        w_blank_next;

    // ------------------------------------------------------------------
    // Decimal increment/decrement. A digit changes when every lower digit
    // is at its rollover value (9 going up, 0 going down); bit 4 of the
    // enable vectors is the carry/borrow out of the thousands digit.
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < 4; i++) begin : g_digit
            assign w_is9[i]   = (r_d[i] == 4'd9);
            assign w_is0[i]   = (r_d[i] == 4'd0);
            assign w_d_inc[i] = !w_inc_en[i] ? r_d[i] :
                                (w_is9[i] ? 4'd0 : r_d[i] + 4'd1);
            assign w_d_dec[i] = !w_dec_en[i] ? r_d[i] :
                                (w_is0[i] ? 4'd9 : r_d[i] - 4'd1);
        end
    endgenerate

    assign w_inc_en = {&w_is9[3:0], &w_is9[2:0], &w_is9[1:0], w_is9[0], 1'b1};
    assign w_dec_en = {&w_is0[3:0], &w_is0[2:0], &w_is0[1:0], w_is0[0], 1'b1};

    // w_zero_from[i]: digits d3..di are all zero
    assign w_zero_from = {w_is0[3], &w_is0[3:2], &w_is0[3:1], &w_is0[3:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_d[i] <= 4'd0;
            end
            r_wrap <= 1'b0;
        end else if (bus.clr) begin
            for (int i = 0; i < 4; i++) begin
                r_d[i] <= 4'd0;
            end
            r_wrap <= 1'b0;
        end else if (bus.step) begin
            for (int i = 0; i < 4; i++) begin
                r_d[i] <= bus.up ? w_d_inc[i] : w_d_dec[i];
            end
            r_wrap <= bus.up ? w_inc_en[4] : w_dec_en[4];
        end else begin
            r_wrap <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Prescaler and slot rotation
    // ------------------------------------------------------------------
    assign w_adv = (r_pre == c_PRE_LAST);

    always_comb begin
        w_slot_next = r_slot;
        case (r_slot)
            c_S0:    w_slot_next = w_adv ? c_S1 : c_S0;
            c_S1:    w_slot_next = w_adv ? c_S2 : c_S1;
            c_S2:    w_slot_next = w_adv ? c_S3 : c_S2;
            c_S3:    w_slot_next = w_adv ? c_S0 : c_S3;
            default: w_slot_next = c_S0;
        endcase
    end

    // Units digit is never blanked so that 0000 still shows one zero.
    assign w_blank_next = (LZB != 0) && (w_slot_next != c_S0) &&
                          w_zero_from[w_slot_next];

    // Digit data, select and blank are all loaded from the upcoming slot in
    // the same edge, so they can never be misaligned at the decoder.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre   <= 16'd0;
            r_slot  <= c_S0;
            r_sel   <= 4'b0001;
            r_dig   <= 4'd0;
            r_blank <= 1'b0;
        end else begin
            r_pre   <= w_adv ? 16'd0 : r_pre + 16'd1;
            r_slot  <= w_slot_next;
            r_sel   <= 4'b0001 << w_slot_next;
            r_dig   <= r_d[w_slot_next];
            r_blank <= w_blank_next;
        end
    end

    assign bus.w         = r_dig[3];
    assign bus.x         = r_dig[2];
    assign bus.y         = r_dig[1];
    assign bus.z         = r_dig[0];
    assign bus.digit_sel = r_sel;
    assign bus.blank     = r_blank;
    assign bus.wrap      = r_wrap;

endmodule
`default_nettype wire

// File: doc/bcd_digit_scanner.md
# bcd_digit_scanner

Four-digit BCD up/down counter with a time-multiplexed digit scanner. It sits directly upstream of the seven-segment decoder. Each cycle it presents one BCD digit on `w,x,y,z`, with `w` as the MSB, together with a one-hot digit select. It rotates through the four digits at a programmable rate so that one decoder can drive a four-digit display.

## Interface
- `SCAN_DIV`, default 4: clock cycles each digit slot is held; legal range 1..65535.
- `LZB`, default 1: enables leading-zero blanking when 1; when 0, `blank` is always 0.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `step` in 1: advance the count by one in the cycle it is sampled high.
- `up` in 1: count direction; 1 = increment, 0 = decrement. Sampled only with `step`.
- `clr` in 1: synchronous clear of the count to 0000.
- `w` out 1: bit 3 (MSB) of the selected BCD digit.
- `x` out 1: bit 2 of the selected digit.
- `y` out 1: bit 1 of the selected digit.
- `z` out 1: bit 0 (LSB) of the selected digit.
- `digit_sel` out 4: one-hot digit enable, active-high; bit 0 = units, bit 3 = thousands.
- `blank` out 1: selected digit is a leading zero and should not be lit.
- `wrap` out 1: one-cycle pulse when the count wraps.

## Operation
- **Count state.** Four BCD digit registers `d3..d0`, each 4 bits, legal values 0..9; value = d3·1000 + d2·100 + d1·10 + d0.
- **Priority per cycle.**
  - `clr` = 1 sets all digits to 0, ignores `step`, and leaves `wrap` at 0.
  - Otherwise, `step` = 1 counts one step in the direction given by `up`.
  - Otherwise, the count holds.
- **Increment.** Decimal ripple: a digit at 9 becomes 0 and carries into the next digit. 9999 → 0000 and asserts `wrap`.
- **Decrement.** Decimal borrow: a digit at 0 becomes 9 and borrows from the next digit. 0000 → 9999 and asserts `wrap`.
- **Wrap pulse.** `wrap` is registered: high for exactly the one cycle after the wrapping edge. Back-to-back wrapping steps give back-to-back pulses.
- **Prescaler.** Counts 0..SCAN_DIV-1 every cycle and is independent of `step` and `clr`.
  - When the prescaler equals SCAN_DIV-1, it returns to 0 and the slot advances.
  - With SCAN_DIV = 1, the slot advances every cycle.
- **Slot sequence.** 2-bit slot state S0→S1→S2→S3→S0. `digit_sel` = 1 << slot.
- **Digit outputs.** `w,x,y,z` are registered in the same edge as `digit_sel`, so the pair is always aligned. They carry d[slot_next] as held before that edge.
- **Blanking (`LZB` = 1).** `blank` = 1 when the selected digit i ≥ 1 and d3..di are all 0. Digit 0 is never blanked; for example, count 0000 shows a single 0. `blank` is registered alongside `digit_sel`.
- **Counting while scanning.** No stalls and no handshakes; `step` may be asserted every cycle.

## Timing
- **Reset values:** `d3..d0` = 0, prescaler = 0, slot = S0, `digit_sel` = 0001, `w,x,y,z` = 0000, `blank` = 0, `wrap` = 0.
- **Slot hold time.** After reset release, S0 is held for SCAN_DIV cycles, then each slot is held for exactly SCAN_DIV cycles.
- **Count latency.** A count change at edge N becomes visible on `w..z` at edge N+1, provided that digit is selected then. Count-to-display latency is therefore 1 cycle.
- **`wrap` latency.** `wrap` rises one edge after the wrapping step edge.
- **Simultaneous events.** `clr` together with `step` clears; `clr` during a pending `wrap` cycle does not suppress that already-registered pulse.
- **Reset mid-operation.** Asynchronous `rst` forces all reset values immediately, independent of `clk`. The first slot advance occurs SCAN_DIV edges after release.
- **Output glitches.** All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Reset and scan.** With SCAN_DIV = 2, release `rst` and hold count 0000.
  - `digit_sel` must go 0001,0001,0010,0010,0100,0100,1000,1000,0001.
  - `w..z` must stay 0000.
  - `blank` must be 0,0,1,1,1,1,1,1.
- **Increment carry.** Load 0099 by 99 `step` pulses with `up` = 1, then one more pulse.
  - Count must read 0100.
  - When S2 is selected, `w..z` must be 0001.
  - `blank` must be high only in S3.
- **Up wrap.** At 9999 with `up` = 1, apply one `step`.
  - Count must read 0000.
  - `wrap` must be high for exactly one cycle, on the edge after the step.
- **Down wrap.** From reset, apply `step` with `up` = 0.
  - Count must read 9999.
  - `wrap` must pulse once.
  - In every slot, `w..z` must be 1001 and `blank` must be 0.
- **Clear priority.** At 1234, assert `clr` and `step` together for one cycle.
  - Count must read 0000.
  - `wrap` must stay 0.
- **Asynchronous reset mid-scan.** Assert `rst` between edges while in S2 with count 0457.
  - All outputs must take their reset values before the next edge.
  - After release, S0 must be held for SCAN_DIV cycles.
